// File: rtl/mult_pkg.sv
// Shared types for the multiplier bus sequencer.
//   func_t      - encoding of the multiplier 'func' port
//   FUNC_IDLE   - alias for the idle/read-high encoding (2'b11)
//   seq_state_t - sequencer FSM states
package mult_pkg;

  typedef enum logic [1:0] {
    FUNC_LOAD_A  = 2'b00,
    FUNC_LOAD_B  = 2'b01,
    FUNC_READ_LO = 2'b10,
    FUNC_READ_HI = 2'b11
  } func_t;

  // With oe low, 2'b11 means "idle". With oe high, it means "read high".
  localparam func_t FUNC_IDLE = FUNC_READ_HI;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_TURN,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_READ_LO,
    ST_READ_HI,
    ST_RESP
  } seq_state_t;

endpackage

// File: rtl/mult_bus_sequencer_rr_arbiter.sv
// Round-robin arbiter that owns the rotating priority pointer.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   req          - request vector, one bit per requester
//   advance      - the current grant is being accepted; move the pointer past the winner
//   grant        - one-hot winner. The search starts at the pointer and wraps.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = PW + 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sum;
  logic [PW-1:0] idx;
  logic          found;

  // Scan from the pointer upwards with wraparound. The first requester found wins.
  // The pointer moves when the grant is taken rather than when the response is sent.
  // The pointer is only consulted in IDLE, so the next decision is the same either way.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    sum   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      sum = {1'b0, ptr_q} + SW'(off);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
    end
    if (!advance) ptr_d = ptr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mult_bus_sequencer.sv
// Shares one multiplier between NREQ requesters.
// A round-robin arbiter picks a requester. The sequencer then runs the multiplier handshake:
// load A, load B, bus turnaround, start, wait for ready to drop and then rise, read low, read high.
// It then returns the 2n-bit product with a one-cycle done pulse.
// Ports:
//   clock, reset      - clock and asynchronous active-high reset
//   req/op_a/op_b     - per-requester level request and operands (slice i = requester i)
//   gnt/done          - one-hot grant (LOAD_A..RESP) and one-cycle done pulse (RESP)
//   result/err        - product, and the timeout flag; both valid with done
//   busy              - high whenever the FSM is not in IDLE
//   start/func/oe     - multiplier control
//   ready             - multiplier status
//   data              - shared tri-state bus, driven here only in LOAD_A/LOAD_B
module mult_bus_sequencer
  import mult_pkg::*;
#(
  parameter int n       = 8,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*n-1:0] op_a,
  input  logic [NREQ*n-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*n-1:0]    result,
  output logic              err,
  output logic              busy,
  output logic              start,
  output logic [1:0]        func,
  output logic              oe,
  input  logic              ready,
  inout  wire  [n-1:0]      data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  seq_state_t       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [n-1:0]     opA_q, opA_d, opB_q, opB_d;
  logic [2*n-1:0]   result_q, result_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NREQ-1:0]  arbGrant;
  logic             arbAdvance;
  logic [n-1:0]     selA, selB;
  func_t            funcS;
  logic             startS, oeS, driveS;
  logic [n-1:0]     busOut;
  logic             timedOut;

  assign arbAdvance = (state_q == ST_IDLE) && (|req);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (arbAdvance),
    .grant   (arbGrant)
  );

  // One-hot operand mux selected by the arbiter's grant.
  always_comb begin
    selA = '0;
    selB = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arbGrant[i]) begin
        selA = selA | op_a[i*n +: n];
        selB = selB | op_b[i*n +: n];
      end
    end
  end

  // The counter holds the number of wait cycles already spent.
  // Reaching TIMEOUT - 1 means the current cycle is the last one allowed.
  assign timedOut = (cnt_q >= CW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    funcS    = FUNC_IDLE;
    startS   = 1'b0;
    oeS      = 1'b0;
    driveS   = 1'b0;
    busOut   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d    = arbGrant;
          opA_d    = selA;
          opB_d    = selB;
          result_d = '0;
          err_d    = 1'b0;
          state_d  = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        funcS   = FUNC_LOAD_A;
        driveS  = 1'b1;
        busOut  = opA_q;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        funcS   = FUNC_LOAD_B;
        driveS  = 1'b1;
        busOut  = opB_q;
        state_d = ST_TURN;
      end
      ST_TURN: state_d = ST_START;
      ST_START: begin
        startS  = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      // A transition that makes progress takes priority over the timeout in the same cycle.
      ST_WAIT_BUSY: begin
        if (!ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_WAIT_DONE;
        end else if (timedOut) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (ready) begin
          state_d = ST_READ_LO;
        end else if (timedOut) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ_LO: begin
        funcS          = FUNC_READ_LO;
        oeS            = 1'b1;
        result_d[n-1:0] = data;
        state_d        = ST_READ_HI;
      end
      ST_READ_HI: begin
        funcS              = FUNC_READ_HI;
        oeS                = 1'b1;
        result_d[2*n-1:n]  = data;
        state_d            = ST_RESP;
      end
      ST_RESP: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are decoded from the registered state.
  // An asynchronous reset therefore releases the bus and clears done at once.
  assign gnt    = gnt_q;
  assign done   = (state_q == ST_RESP) ? gnt_q : '0;
  assign result = result_q;
  assign err    = err_q;
  assign busy   = (state_q != ST_IDLE);
  assign start  = startS;
  assign func   = funcS;
  assign oe     = oeS;
  assign data   = driveS ? busOut : 'z;

  noBusContention: assert property (@(posedge clock) disable iff (reset) !(oeS && driveS));

endmodule

// File: tb/tb_mult_bus_sequencer.sv
// Self-checking bench for mult_bus_sequencer.
// It contains a behavioural multiplier on the shared bus. That multiplier has a settable latency and a stub mode that holds ready high.
module tb_mult_bus_sequencer;

  localparam int N       = 8;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [1:0]  doneExp;
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [15:0]  opA, opB;
  logic [1:0]   gnt, done;
  logic [15:0]  result;
  logic         err, busy, start, oe, ready;
  logic [1:0]   func;
  wire  [7:0]   dataBus;

  int testsRun  = 0;
  int failCount = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  mult_bus_sequencer #(.n(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .op_a   (opA),
    .op_b   (opB),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .err    (err),
    .busy   (busy),
    .start  (start),
    .func   (func),
    .oe     (oe),
    .ready  (ready),
    .data   (dataBus)
  );

  // Behavioural multiplier. Ready is low for mulLatency cycles after start.
  logic [7:0]  mA, mB;
  logic [15:0] prod;
  logic        readyQ;
  int          busyCnt;
  int          mulLatency = 3;
  bit          stubMode = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mA <= '0; mB <= '0; prod <= '0; readyQ <= 1'b1; busyCnt <= 0;
    end else begin
      if (!oe && func == 2'b00) mA <= dataBus;
      if (!oe && func == 2'b01) mB <= dataBus;
      if (start && !stubMode) begin
        readyQ  <= 1'b0;
        busyCnt <= mulLatency - 1;
      end else if (!readyQ) begin
        if (busyCnt == 0) begin
          readyQ <= 1'b1;
          prod   <= 16'(mA) * 16'(mB);
        end else begin
          busyCnt <= busyCnt - 1;
        end
      end
    end
  end

  assign ready   = stubMode ? 1'b1 : readyQ;
  assign dataBus = oe ? (func[0] ? prod[15:8] : prod[7:0]) : 8'bz;

  function automatic exp_t popExp();
    exp_t e;
    e = '{doneExp: 2'b11, res: 16'hFFFF, err: 1'b1};
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // Waits, starting from a negedge, until done is seen high or the budget runs out.
  task automatic waitDone(input int maxCycles, output int cycles, output bit seen,
                          output logic [1:0] gntOr);
    seen = 1'b0; cycles = 0; gntOr = '0;
    while (!seen && cycles < maxCycles) begin
      @(posedge clock); cycles++;
      @(negedge clock);
      gntOr = gntOr | gnt;
      if (done != 2'b00) seen = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [15:0] a, input logic [15:0] b);
    @(negedge clock);
    req = r; opA = a; opB = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; opA = '0; opB = '0;
    repeat (2) @(negedge clock);
    testsRun++;
    if ({gnt, done, result, err, busy, start, func, oe} !== {2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL reset_values: got gnt=%b done=%b result=%h err=%b busy=%b start=%b func=%b oe=%b expected 00 00 0000 0 0 0 11 0",
               gnt, done, result, err, busy, start, func, oe);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_load_bus();
    int cyc; bit seen; logic [1:0] go; exp_t e;
    applyStimulus(2'b01, 16'd123, 16'd234);
    sb.push_back('{doneExp: 2'b01, res: 16'd28782, err: 1'b0});
    @(negedge clock);
    testsRun++;
    if (func !== 2'b00 || dataBus !== 8'd123 || gnt !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL t1_load_a: got func=%b data=%0d gnt=%b expected 00 123 01", func, dataBus, gnt);
    end
    @(negedge clock);
    testsRun++;
    if (func !== 2'b01 || dataBus !== 8'd234) begin
      failCount++;
      $display("[TB] FAIL t1_load_b: got func=%b data=%0d expected 01 234", func, dataBus);
    end
    waitDone(60, cyc, seen, go);
    req = 2'b00;
    e = popExp();
    testsRun++;
    if (!seen) begin
      failCount++;
      $display("[TB] FAIL t1_timeout: no done within budget");
    end else if (done !== e.doneExp || result !== e.res || err !== e.err) begin
      failCount++;
      $display("[TB] FAIL t1_result: got done=%b result=%h err=%b expected %b %h %b", done, result, err, e.doneExp, e.res, e.err);
    end
    testsRun++;
    if (cyc + 2 != 8 + mulLatency) begin
      failCount++;
      $display("[TB] FAIL t1_latency: got %0d cycles expected %0d", cyc + 2, 8 + mulLatency);
    end
    @(negedge clock);
    testsRun++;
    if (done !== 2'b00 || gnt !== 2'b00 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL t1_after_done: got done=%b gnt=%b busy=%b expected 00 00 0", done, gnt, busy);
    end
  endtask

  task automatic test_req1();
    int cyc; bit seen; logic [1:0] go; exp_t e;
    applyStimulus(2'b10, 16'h5500, 16'hAA00);
    sb.push_back('{doneExp: 2'b10, res: 16'h3872, err: 1'b0});
    waitDone(60, cyc, seen, go);
    req = 2'b00;
    e = popExp();
    testsRun++;
    if (!seen || done !== e.doneExp || result !== e.res || err !== e.err) begin
      failCount++;
      $display("[TB] FAIL t2_result: got seen=%b done=%b result=%h err=%b expected 1 %b %h %b", seen, done, result, err, e.doneExp, e.res, e.err);
    end
    testsRun++;
    if (go !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL t2_gnt0_quiet: got gnt history %b expected 10", go);
    end
    @(negedge clock);
  endtask

  task automatic test_simultaneous();
    int cyc; bit seen; logic [1:0] go; exp_t e;
    applyStimulus(2'b11, {8'd200, 8'd12}, {8'd3, 8'd13});
    sb.push_back('{doneExp: 2'b01, res: 16'd156, err: 1'b0});
    sb.push_back('{doneExp: 2'b10, res: 16'd600, err: 1'b0});
    sb.push_back('{doneExp: 2'b01, res: 16'd156, err: 1'b0});
    for (int k = 0; k < 3; k++) begin
      waitDone(60, cyc, seen, go);
      if (k == 2) req = 2'b00;
      e = popExp();
      testsRun++;
      if (!seen || done !== e.doneExp || result !== e.res || err !== e.err) begin
        failCount++;
        $display("[TB] FAIL t3_order%0d: got seen=%b done=%b result=%0d err=%b expected 1 %b %0d %b", k, seen, done, result, err, e.doneExp, e.res, e.err);
      end
    end
    repeat (2) @(negedge clock);
    testsRun++;
    if (busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL t3_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_timeout();
    int cyc; bit seen; logic [1:0] go; exp_t e;
    stubMode = 1'b1;
    applyStimulus(2'b01, 16'd5, 16'd7);
    sb.push_back('{doneExp: 2'b01, res: 16'h0000, err: 1'b1});
    waitDone(200, cyc, seen, go);
    req = 2'b00;
    e = popExp();
    testsRun++;
    if (!seen || done !== e.doneExp || result !== e.res || err !== e.err) begin
      failCount++;
      $display("[TB] FAIL t4_timeout_resp: got seen=%b done=%b result=%h err=%b expected 1 %b %h %b", seen, done, result, err, e.doneExp, e.res, e.err);
    end
    testsRun++;
    if (cyc != 5 + TIMEOUT) begin
      failCount++;
      $display("[TB] FAIL t4_timeout_latency: got %0d cycles expected %0d", cyc, 5 + TIMEOUT);
    end
    @(negedge clock);
    testsRun++;
    if (busy !== 1'b0 || done !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL t4_back_idle: got busy=%b done=%b expected 0 00", busy, done);
    end
    stubMode = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc; bit seen; logic [1:0] go; exp_t e;
    bit anyDone;
    mulLatency = 20;
    applyStimulus(2'b01, 16'd9, 16'd9);
    repeat (8) @(posedge clock);
    @(negedge clock);
    testsRun++;
    if (busy !== 1'b1 || gnt !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL t5_pre_reset: got busy=%b gnt=%b expected 1 01", busy, gnt);
    end
    #2 reset = 1'b1; req = 2'b00;
    #1;
    testsRun++;
    if ({gnt, done, result, err, busy, start, func, oe} !== {2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL t5_async_reset: got gnt=%b done=%b result=%h err=%b busy=%b start=%b func=%b oe=%b expected 00 00 0000 0 0 0 11 0",
               gnt, done, result, err, busy, start, func, oe);
    end
    @(negedge clock);
    reset = 1'b0;
    mulLatency = 3;
    anyDone = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (done !== 2'b00) anyDone = 1'b1;
    end
    testsRun++;
    if (anyDone) begin
      failCount++;
      $display("[TB] FAIL t5_no_done: got a done pulse after abort expected none");
    end
    applyStimulus(2'b01, 16'd17, 16'd19);
    sb.push_back('{doneExp: 2'b01, res: 16'd323, err: 1'b0});
    waitDone(60, cyc, seen, go);
    req = 2'b00;
    e = popExp();
    testsRun++;
    if (!seen || done !== e.doneExp || result !== e.res || err !== e.err) begin
      failCount++;
      $display("[TB] FAIL t5_recover: got seen=%b done=%b result=%0d err=%b expected 1 %b %0d %b", seen, done, result, err, e.doneExp, e.res, e.err);
    end
    @(negedge clock);
  endtask

  task automatic test_edge_operands();
    int cyc; bit seen; logic [1:0] go; exp_t e;
    applyStimulus(2'b01, 16'h00FF, 16'h00FF);
    sb.push_back('{doneExp: 2'b01, res: 16'hFE01, err: 1'b0});
    @(negedge clock);
    opA = 16'h0001;
    waitDone(60, cyc, seen, go);
    req = 2'b00;
    e = popExp();
    testsRun++;
    if (!seen || done !== e.doneExp || result !== e.res || err !== e.err) begin
      failCount++;
      $display("[TB] FAIL t6_ff_ff: got seen=%b done=%b result=%h err=%b expected 1 %b %h %b", seen, done, result, err, e.doneExp, e.res, e.err);
    end
    @(negedge clock);
    applyStimulus(2'b01, 16'h0000, 16'h00FF);
    sb.push_back('{doneExp: 2'b01, res: 16'h0000, err: 1'b0});
    waitDone(60, cyc, seen, go);
    req = 2'b00;
    e = popExp();
    testsRun++;
    if (!seen || done !== e.doneExp || result !== e.res || err !== e.err) begin
      failCount++;
      $display("[TB] FAIL t6_zero: got seen=%b done=%b result=%h err=%b expected 1 %b %h %b", seen, done, result, err, e.doneExp, e.res, e.err);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_load_bus();
    test_req1();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_edge_operands();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
